// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side burst master.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Occupancy counters need one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry valid/ready buffer carrying {last, data}; a word arriving while empty passes straight through.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic             wr_last,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic             rd_last,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       occ
);

  logic           v0, v1;
  logic [WIDTH:0] e0, e1;
  logic [WIDTH:0] wr_ent;
  logic           fire;

  assign wr_ent   = {wr_last, wr_data};
  assign rd_valid = v0 | wr_valid;
  assign {rd_last, rd_data} = v0 ? e0 : (wr_valid ? wr_ent : '0);
  assign fire     = rd_valid & rd_ready;
  assign occ      = {1'b0, v0} + {1'b0, v1};

  // e0 is always the head; e1 only fills when the head is stalled and another word lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      case ({v1, v0})
        2'b00: begin
          if (wr_valid && !rd_ready) begin
            e0 <= wr_ent;
            v0 <= 1'b1;
          end
        end
        2'b01: begin
          if (fire) begin
            if (wr_valid) e0 <= wr_ent;
            else          v0 <= 1'b0;
          end else if (wr_valid) begin
            e1 <= wr_ent;
            v1 <= 1'b1;
          end
        end
        default: begin
          if (fire) begin
            e0 <= e1;
            if (wr_valid) e1 <= wr_ent;
            else          v1 <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the synchronous FIFO: pops fixed or flush-length bursts into a valid/ready stream.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int BURST_LEN = 4,
  localparam int CNT_W     = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data_out,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      burst_done_cnt
);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] issue_left;
  logic [CNT_W-1:0] emit_left;
  logic             inflight_p1;
  logic             last_p1;
  logic [1:0]       occ;
  logic             pop_out;

  assign pop_out = m_valid & m_ready;
  assign busy    = (state != ST_IDLE);

  // Never let buffered + in-flight words exceed the two buffer slots.
  assign fifo_rd_en = !rst && (state != ST_IDLE) && (issue_left != '0) && !fifo_empty &&
                      (({1'b0, occ} + {2'b00, inflight_p1}) < (3'd2 + {2'b00, pop_out}));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      issue_left     <= '0;
      emit_left      <= '0;
      inflight_p1    <= 1'b0;
      last_p1        <= 1'b0;
      burst_done_cnt <= '0;
    end else begin
      inflight_p1 <= fifo_rd_en;
      last_p1     <= fifo_rd_en && (issue_left == ONE);
      case (state)
        ST_IDLE: begin
          if (fifo_count >= BURST_CNT) begin
            state      <= ST_BURST;
            issue_left <= BURST_CNT;
            emit_left  <= BURST_CNT;
          end else if (flush && (fifo_count != '0)) begin
            state      <= ST_FLUSH;
            issue_left <= fifo_count;
            emit_left  <= fifo_count;
          end
        end
        default: begin
          if (fifo_rd_en) issue_left <= issue_left - ONE;
          if (pop_out)    emit_left  <= emit_left - ONE;
          if (pop_out && (emit_left == ONE)) begin
            state          <= ST_IDLE;
            burst_done_cnt <= burst_done_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // The word popped with issue_left == 1 is the burst's final word; its tag travels with the data.
  fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (inflight_p1),
    .wr_last  (last_p1),
    .wr_data  (fifo_data_out),
    .rd_ready (m_ready),
    .rd_valid (m_valid),
    .rd_last  (m_last),
    .rd_data  (m_data),
    .occ      (occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, stream monitor and a burst-splitting reference model.
module tb_fifo_burst_reader;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int BL = 4;
  localparam int CW = $clog2(D) + 1;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A (BURST_LEN = 4)
  logic          rd_a, empty_a = 1'b1, flush_a = 1'b0, mr_a = 1'b1;
  logic          mv_a, ml_a, busy_a;
  logic [W-1:0]  dout_a = '0, md_a;
  logic [CW-1:0] cnt_a = '0;
  logic [15:0]   bdc_a;
  // DUT B (BURST_LEN = 1)
  logic          rd_b, empty_b = 1'b1, flush_b = 1'b0, mr_b = 1'b1;
  logic          mv_b, ml_b, busy_b;
  logic [W-1:0]  dout_b = '0, md_b;
  logic [CW-1:0] cnt_b = '0;
  logic [15:0]   bdc_b;

  fifo_burst_reader #(.WIDTH(W), .DEPTH(D), .BURST_LEN(BL)) dut_a (
    .clk(clk), .rst(rst), .fifo_rd_en(rd_a), .fifo_data_out(dout_a), .fifo_empty(empty_a),
    .fifo_count(cnt_a), .flush(flush_a), .m_data(md_a), .m_valid(mv_a), .m_ready(mr_a),
    .m_last(ml_a), .busy(busy_a), .burst_done_cnt(bdc_a)
  );

  fifo_burst_reader #(.WIDTH(W), .DEPTH(D), .BURST_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .fifo_rd_en(rd_b), .fifo_data_out(dout_b), .fifo_empty(empty_b),
    .fifo_count(cnt_b), .flush(flush_b), .m_data(md_b), .m_valid(mv_b), .m_ready(mr_b),
    .m_last(ml_b), .busy(busy_b), .burst_done_cnt(bdc_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural FIFOs: registered data_out, count and empty.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic         push_a = 1'b0, push_b = 1'b0;
  logic [W-1:0] pdata_a = '0, pdata_b = '0;
  int           under_a = 0;

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      dout_a <= '0;
    end else begin
      if (rd_a) begin
        if (qa.size() > 0) dout_a <= qa.pop_front();
        else under_a <= under_a + 1;
      end
      if (push_a) qa.push_back(pdata_a);
    end
    cnt_a   <= CW'(qa.size());
    empty_a <= (qa.size() == 0);
  end

  always @(posedge clk) begin
    if (rst) begin
      qb.delete();
      dout_b <= '0;
    end else begin
      if (rd_b && qb.size() > 0) dout_b <= qb.pop_front();
      if (push_b) qb.push_back(pdata_b);
    end
    cnt_b   <= CW'(qb.size());
    empty_b <= (qb.size() == 0);
  end

  // Stream monitors
  beat_t got_a[$];
  beat_t got_b[$];
  int    stall_err = 0, occ_err = 0, issued_a = 0, accepted_a = 0;
  logic  held = 1'b0;
  beat_t held_beat = '0;

  always @(posedge clk) begin : mon_a
    int ni, na;
    if (rst) begin
      held       <= 1'b0;
      issued_a   <= 0;
      accepted_a <= 0;
    end else begin
      if (held && (!mv_a || {ml_a, md_a} != held_beat)) stall_err <= stall_err + 1;
      if (mv_a && mr_a) got_a.push_back({ml_a, md_a});
      ni = issued_a + (rd_a ? 1 : 0);
      na = accepted_a + ((mv_a && mr_a) ? 1 : 0);
      if (ni - na > 2) occ_err <= occ_err + 1;
      issued_a   <= ni;
      accepted_a <= na;
      held       <= mv_a && !mr_a;
      held_beat  <= {ml_a, md_a};
    end
  end

  always @(posedge clk) begin
    if (!rst && mv_b && mr_b) got_b.push_back({ml_b, md_b});
  end

  // m_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  int ready_mode = 0;
  int rdy_cyc = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0:       mr_a = 1'b1;
      1:       begin mr_a = (rdy_cyc % 3 == 0); rdy_cyc = rdy_cyc + 1; end
      default: mr_a = 1'($urandom_range(0, 1));
    endcase
  end

  logic [W-1:0] sent_a[$];
  int           exp_bdc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_words_a(input int n, input logic [W-1:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      step();
      pdata_a = rnd ? W'($urandom) : base + W'(i);
      push_a  = 1'b1;
      sent_a.push_back(pdata_a);
    end
    step();
    push_a = 1'b0;
  endtask

  task automatic flush_pulse_a();
    step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
  endtask

  task automatic wait_beats_a(input string tag, input int n, input int limit);
    int c = 0;
    while (got_a.size() < n && c < limit) begin
      step();
      c++;
    end
    check({tag, "_beats_seen"}, got_a.size(), n);
  endtask

  // Reference: words leave in push order, grouped into blen bursts; a flush drains the remainder as one burst.
  task automatic compare_stream(input string tag, input int blen, input bit with_tail);
    int n   = sent_a.size();
    int k   = (n / blen) * blen;
    int tot = with_tail ? n : k;
    check({tag, "_count"}, got_a.size(), tot);
    for (int i = 0; i < tot && i < got_a.size(); i++) begin
      logic exp_last;
      exp_last = (i < k) ? ((i % blen) == blen - 1) : (i == n - 1);
      check($sformatf("%s_data%0d", tag, i), got_a[i].data, sent_a[i]);
      check($sformatf("%s_last%0d", tag, i), got_a[i].last, exp_last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_rd_en", rd_a, 1'b0);
    check("rst_valid", mv_a, 1'b0);
    check("rst_last",  ml_a, 1'b0);
    check("rst_data",  md_a, 8'h00);
    check("rst_busy",  busy_a, 1'b0);
    check("rst_bdc",   bdc_a, 16'd0);
    rst = 1'b0;
    step();

    // 1: burst of 4 with m_ready held high, cycle-exact latency
    ready_mode = 0;
    push_words_a(4, 8'hA1, 1'b0);
    check("t1_count4", cnt_a, CW'(4));
    check("t1_rd_idle", rd_a, 1'b0);
    step();
    check("t1_rd_first", rd_a, 1'b1);
    check("t1_valid_early", mv_a, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t1_valid%0d", i), mv_a, 1'b1);
      check($sformatf("t1_data%0d", i), md_a, 8'hA1 + 8'(i));
      check($sformatf("t1_last%0d", i), ml_a, (i == 3));
    end
    step();
    exp_bdc++;
    check("t1_valid_after", mv_a, 1'b0);
    check("t1_busy_after", busy_a, 1'b0);
    check("t1_bdc", bdc_a, 16'(exp_bdc));
    compare_stream("t1", BL, 1'b0);

    // 2: backpressure pattern 1,0,0,...
    sent_a.delete(); got_a.delete();
    ready_mode = 1;
    push_words_a(4, 8'hA1, 1'b0);
    wait_beats_a("t2", 4, 100);
    repeat (3) step();
    exp_bdc++;
    compare_stream("t2", BL, 1'b0);
    check("t2_bdc", bdc_a, 16'(exp_bdc));
    check("t2_stall_stable", stall_err, 0);
    check("t2_outstanding", occ_err, 0);

    // 3: flush of a 3-word partial burst, then flush on an empty FIFO
    sent_a.delete(); got_a.delete();
    ready_mode = 0;
    push_words_a(3, 8'h10, 1'b0);
    repeat (3) step();
    check("t3_idle_before_flush", busy_a, 1'b0);
    flush_pulse_a();
    check("t3_busy_flush", busy_a, 1'b1);
    wait_beats_a("t3", 3, 100);
    repeat (2) step();
    exp_bdc++;
    compare_stream("t3", BL, 1'b1);
    check("t3_idle_after", busy_a, 1'b0);
    check("t3_bdc", bdc_a, 16'(exp_bdc));
    flush_pulse_a();
    check("t3_flush_empty_busy", busy_a, 1'b0);
    step();
    check("t3_flush_empty_bdc", bdc_a, 16'(exp_bdc));

    // 4: nine random words -> two full bursts, ninth waits for flush
    sent_a.delete(); got_a.delete();
    ready_mode = 2;
    push_words_a(9, 8'h00, 1'b1);
    wait_beats_a("t4", 8, 300);
    repeat (4) step();
    exp_bdc += 2;
    compare_stream("t4a", BL, 1'b0);
    check("t4_leftover", cnt_a, CW'(1));
    check("t4_idle", busy_a, 1'b0);
    flush_pulse_a();
    wait_beats_a("t4f", 9, 100);
    repeat (2) step();
    exp_bdc++;
    compare_stream("t4b", BL, 1'b1);
    check("t4_bdc", bdc_a, 16'(exp_bdc));

    // 5: reset after two of four words accepted
    sent_a.delete(); got_a.delete();
    ready_mode = 0;
    push_words_a(4, 8'hA1, 1'b0);
    wait_beats_a("t5_pre", 2, 50);
    rst = 1'b1;
    #1;
    check("t5_rd_in_rst", rd_a, 1'b0);
    step();
    check("t5_valid", mv_a, 1'b0);
    check("t5_busy", busy_a, 1'b0);
    check("t5_bdc", bdc_a, 16'd0);
    check("t5_rd_in_rst2", rd_a, 1'b0);
    rst = 1'b0;
    exp_bdc = 0;
    repeat (3) step();
    check("t5_no_more_beats", got_a.size(), 2);

    // Randomized rounds: random length, random backpressure, flush for any remainder
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      sent_a.delete(); got_a.delete();
      n = $urandom_range(1, 12);
      k = (n / BL) * BL;
      push_words_a(n, 8'h00, 1'b1);
      wait_beats_a($sformatf("rnd%0d", r), k, 400);
      repeat (4) step();
      exp_bdc += n / BL;
      if (n % BL != 0) begin
        flush_pulse_a();
        wait_beats_a($sformatf("rnd%0df", r), n, 200);
        repeat (2) step();
        exp_bdc++;
      end
      compare_stream($sformatf("rnd%0d", r), BL, 1'b1);
      check($sformatf("rnd%0d_bdc", r), bdc_a, 16'(exp_bdc));
      check($sformatf("rnd%0d_idle", r), busy_a, 1'b0);
    end
    check("stall_stable_all", stall_err, 0);
    check("outstanding_all", occ_err, 0);
    check("fifo_underflow", under_a, 0);

    // 6: BURST_LEN = 1, three words
    for (int i = 0; i < 3; i++) begin
      step();
      pdata_b = 8'h30 + 8'(i);
      push_b  = 1'b1;
    end
    step();
    push_b = 1'b0;
    for (int c = 0; c < 50 && got_b.size() < 3; c++) step();
    repeat (2) step();
    check("t6_beats", got_b.size(), 3);
    for (int i = 0; i < 3 && i < got_b.size(); i++) begin
      check($sformatf("t6_data%0d", i), got_b[i].data, 8'h30 + 8'(i));
      check($sformatf("t6_last%0d", i), got_b[i].last, 1'b1);
    end
    check("t6_bdc", bdc_b, 16'd3);
    check("t6_idle", busy_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's synchronous FIFO.
- Drives the FIFO read port (rd_en, then registered data_out one cycle later) and reformats popped words into a valid/ready stream with a last-word marker.
- Drains in fixed-length bursts once enough words are stored, or in a short flush burst on request.
- Sits between the FIFO and any downstream stream consumer (packetiser, UART TX, DMA).

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- DEPTH, 16, FIFO depth; FIFO occupancy width CNT_W = $clog2(DEPTH)+1 (localparam).
- BURST_LEN, 4, words per normal burst; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_data_out  in  WIDTH  FIFO read data; valid the cycle after an accepted pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  CNT_W  FIFO occupancy.
- flush  in  1  level request to drain a partial burst.
- m_data  out  WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of a burst.
- busy  out  1  high whenever state is not IDLE.
- burst_done_cnt  out  16  number of completed bursts; wraps modulo 2^16.

Behaviour:
- Reset:
  - rst is sampled on the rising clk edge.
  - Reset clears state to IDLE; m_valid, m_last, m_data, burst_done_cnt, the buffer and the in-flight flag all go to 0.
  - fifo_rd_en is forced to 0 while rst is high.
- States: IDLE, BURST, FLUSH.
  - IDLE to BURST when fifo_count >= BURST_LEN; remaining-to-issue (issue_left) and remaining-to-emit (emit_left) both load BURST_LEN.
  - IDLE to FLUSH when flush=1 and 0 < fifo_count < BURST_LEN; both counters load fifo_count.
  - BURST wins when both conditions hold.
  - flush is ignored outside IDLE, and ignored when fifo_count=0.
  - BURST or FLUSH return to IDLE on the cycle the m_last word is accepted (m_valid & m_ready & m_last). burst_done_cnt increments on that same edge.
- Pop rule:
  - fifo_rd_en = (state != IDLE) & (issue_left != 0) & !fifo_empty & (occ + inflight − pop_out < 2).
  - occ is the buffer occupancy (0..2); inflight is fifo_rd_en registered; pop_out = m_valid & m_ready.
  - issue_left decrements on each fifo_rd_en.
- Capture: when inflight=1, fifo_data_out is written into the 2-entry output buffer on that edge.
- Latency:
  - Condition seen in cycle N: state changes at edge N+1, so fifo_rd_en goes high in cycle N+1.
  - The first m_valid is high in cycle N+2.
- Throughput: one word per cycle sustained while m_ready=1 and the FIFO is not empty.
- m_ready backpressure: m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0. The buffer never overflows, because at most 2 words are buffered or in flight.
- m_last is 1 exactly on the word where emit_left = 1; emit_left decrements per accepted output.
- FIFO empties mid-burst (should not happen; the block is the sole reader): fifo_rd_en stalls and the burst resumes when data arrives. No timeout.
- BURST_LEN = 1: every word carries m_last, and state returns to IDLE after each word.
- Reset mid-burst:
  - Buffered and in-flight words are discarded; no m_last is emitted.
  - System integration resets the FIFO and this block together.
- m_valid never depends combinationally on m_ready. fifo_rd_en may depend combinationally on m_ready.

Decomposition:
- Shared package/header fifo_pkg:
  - state encoding localparams (ST_IDLE=2'd0, ST_BURST=2'd1, ST_FLUSH=2'd2);
  - the CNT_W derivation;
  - the WIDTH/DEPTH defaults, shared with sync_fifo.
- One sub-module, fifo_out_buf:
  - 2-entry valid/ready skid buffer carrying {last, data};
  - exposes occ.
- The top level holds the FSM, counters and pop logic.

Test Plan:
1. Fill 4 words 0xA1..0xA4 with m_ready=1 held. Expect fifo_rd_en one cycle after fifo_count=4, the first m_valid two cycles after, 4 back-to-back beats, m_last on 0xA4 only, and burst_done_cnt=1.
2. Burst of 4 with m_ready toggling 1,0,0,1,... Expect data held stable during stalls, no duplicates or losses, order 0xA1..0xA4, and fifo_rd_en never pushing occ+inflight above 2.
3. 3 words 0x10..0x12 stored, flush=1 for one cycle. Expect a FLUSH burst of 3 with m_last on 0x12, then return to IDLE; flush with fifo_count=0 leaves state IDLE.
4. 9 words stored, BURST_LEN=4. Expect two bursts (4+4) with m_last on words 4 and 8; the ninth word stays in the FIFO until flush.
5. rst asserted after 2 of 4 words are accepted. Expect m_valid=0, busy=0 and burst_done_cnt=0 on the next cycle, and fifo_rd_en=0 while rst=1.
6. Parameter BURST_LEN=1 with 3 words stored. Expect 3 single-beat bursts each with m_last=1, and burst_done_cnt=3.
